// File: rtl/dbus_peri_initiator.sv
// dbus-to-peripheral initiator: accepts one LSU load/store at a time, decodes
// the address to a one-hot peripheral slot, runs the req/ack handshake and
// returns a single-cycle response.
// Optional feature: define DBUS_TIMEOUT_EN to bound the WAIT state with an
// 8-bit cycle counter that answers with an error on expiry.

package dbus_peri_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] w_data;
    logic        w_en;
    logic        req;
  } type_dbus2peri_s;

  typedef struct packed {
    logic [31:0] r_data;
    logic        ack;
  } type_peri2dbus_s;

endpackage

module dbus_peri_initiator
  import dbus_peri_pkg::*;
#(
  parameter int unsigned NUM_PERI       = 4,
  parameter logic [31:0] PERI_BASE      = 32'h9000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            lsu_req_i,
  input  logic                            lsu_w_en_i,
  input  logic [31:0]                     lsu_addr_i,
  input  logic [31:0]                     lsu_w_data_i,
  output logic                            lsu_ready_o,
  output logic                            lsu_rsp_o,
  output logic [31:0]                     lsu_r_data_o,
  output logic                            lsu_err_o,
  output type_dbus2peri_s                 dbus2peri_o,
  output logic [NUM_PERI-1:0]             peri_sel_o,
  input  type_peri2dbus_s [NUM_PERI-1:0]  peri2dbus_i
);

  localparam int unsigned SEL_W = NUM_PERI;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e             state_q, state_d;
  logic               req_q, req_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               wen_q, wen_d;
  logic               ready_q, ready_d;
  logic               rsp_q, rsp_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;

  logic [3:0]         idx_c;
  logic               mapped_c;
  logic [SEL_W-1:0]   sel_onehot_c;
  logic               ack_c;
  logic [31:0]        ack_rdata_c;
  logic               timeout_c;

  // Address decode of the incoming LSU request
  always_comb begin
    idx_c        = lsu_addr_i[11:8];
    mapped_c     = (lsu_addr_i[31:12] == PERI_BASE[31:12]) && (32'(idx_c) < NUM_PERI);
    sel_onehot_c = SEL_W'(1) << idx_c;
  end

  // Only the selected slot's ack and read data are seen
  always_comb begin
    ack_c       = 1'b0;
    ack_rdata_c = '0;
    for (int unsigned s = 0; s < NUM_PERI; s++) begin
      if (sel_q[s]) begin
        ack_c       = ack_c | peri2dbus_i[s].ack;
        ack_rdata_c = ack_rdata_c | peri2dbus_i[s].r_data;
      end
    end
  end

`ifdef DBUS_TIMEOUT_EN
  localparam int unsigned CNT_W = 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter is zero outside WAIT so it restarts on every WAIT entry
  always_comb begin
    cnt_d = (state_q == ST_WAIT) ? cnt_q + CNT_W'(1) : '0;
  end

  // WAIT cycle counter register
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_c = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic; an ack takes priority over timeout expiry
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (lsu_req_i) state_d = mapped_c ? ST_WAIT : ST_RESP;
      ST_WAIT: if (ack_c || timeout_c) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered bus and LSU outputs
  always_comb begin
    req_d   = req_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wen_d   = wen_q;
    rdata_d = '0;
    err_d   = 1'b0;
    ready_d = (state_d == ST_IDLE);
    rsp_d   = (state_d == ST_RESP);
    case (state_q)
      ST_IDLE: begin
        if (lsu_req_i) begin
          if (mapped_c) begin
            req_d   = 1'b1;
            sel_d   = sel_onehot_c;
            addr_d  = lsu_addr_i;
            wdata_d = lsu_w_data_i;
            wen_d   = lsu_w_en_i;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (ack_c) begin
          req_d   = 1'b0;
          sel_d   = '0;
          rdata_d = wen_q ? 32'h0 : ack_rdata_c;
        end else if (timeout_c) begin
          req_d = 1'b0;
          sel_d = '0;
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q   <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      ready_q <= 1'b1;
      rsp_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      req_q   <= req_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      ready_q <= ready_d;
      rsp_q   <= rsp_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign lsu_ready_o  = ready_q;
  assign lsu_rsp_o    = rsp_q;
  assign lsu_r_data_o = rdata_q;
  assign lsu_err_o    = err_q;
  assign peri_sel_o   = sel_q;
  assign dbus2peri_o  = '{addr: addr_q, w_data: wdata_q, w_en: wen_q, req: req_q};

endmodule

// File: tb/tb_dbus_peri_initiator.sv
// Bench for dbus_peri_initiator: scoreboard of expected LSU responses checked
// by a monitor on every rsp pulse, plus directed checks of the bus side.
module tb_dbus_peri_initiator;
  import dbus_peri_pkg::*;

  localparam int unsigned NUM_PERI = 4;

  logic                           clk = 1'b0;
  logic                           rst_n;
  logic                           lsu_req_i;
  logic                           lsu_w_en_i;
  logic [31:0]                    lsu_addr_i;
  logic [31:0]                    lsu_w_data_i;
  logic                           lsu_ready_o;
  logic                           lsu_rsp_o;
  logic [31:0]                    lsu_r_data_o;
  logic                           lsu_err_o;
  type_dbus2peri_s                dbus2peri_o;
  logic [NUM_PERI-1:0]            peri_sel_o;
  type_peri2dbus_s [NUM_PERI-1:0] peri2dbus_i;

  always #5 clk = ~clk;

  dbus_peri_initiator #(
    .NUM_PERI(NUM_PERI), .PERI_BASE(32'h9000_0000), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_req_i(lsu_req_i), .lsu_w_en_i(lsu_w_en_i),
    .lsu_addr_i(lsu_addr_i), .lsu_w_data_i(lsu_w_data_i),
    .lsu_ready_o(lsu_ready_o), .lsu_rsp_o(lsu_rsp_o),
    .lsu_r_data_o(lsu_r_data_o), .lsu_err_o(lsu_err_o),
    .dbus2peri_o(dbus2peri_o), .peri_sel_o(peri_sel_o),
    .peri2dbus_i(peri2dbus_i)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  // Responder models: ack one cycle after seeing req+sel, single-cycle pulse
  logic [NUM_PERI-1:0] ack_q;
  logic [NUM_PERI-1:0] ack_en;
  logic [NUM_PERI-1:0] stray;
  logic [31:0]         rd [NUM_PERI];

  always @(posedge clk) begin
    for (int s = 0; s < NUM_PERI; s++) begin
      if (!rst_n) ack_q[s] <= 1'b0;
      else ack_q[s] <= ack_en[s] && dbus2peri_o.req && peri_sel_o[s] && !ack_q[s];
    end
  end

  always_comb begin
    for (int s = 0; s < NUM_PERI; s++) begin
      peri2dbus_i[s].ack    = ack_q[s] | stray[s];
      peri2dbus_i[s].r_data = rd[s];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse is compared with the scoreboard head
  always @(negedge clk) begin
    if (rst_n === 1'b1 && lsu_rsp_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got rsp r_data=%h err=%b expected no rsp",
                 lsu_r_data_o, lsu_err_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_r_data", lsu_r_data_o, e.rdata);
        check("rsp_err", 32'(lsu_err_o), 32'(e.err));
      end
    end
  end

  task automatic push(input logic [31:0] rdata, input logic err);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; waits (bounded) for ready
  task automatic wait_ready();
    int n = 0;
    while (lsu_ready_o !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got ready=%b expected 1 within 200 cycles", lsu_ready_o);
    end
  endtask

  // Present one request, return at the negedge after the accepting edge
  task automatic accept(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input bit hold);
    wait_ready();
    lsu_req_i    = 1'b1;
    lsu_w_en_i   = we;
    lsu_addr_i   = a;
    lsu_w_data_i = wd;
    @(posedge clk);
    @(negedge clk);
    if (!hold) lsu_req_i = 1'b0;
  endtask

  // Count cycles req stays high, starting at the current negedge
  task automatic count_req(output int n);
    n = 0;
    while (dbus2peri_o.req === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  logic [31:0] b2b_addr [3];
  logic [31:0] b2b_data [3];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n        = 1'b0;
    lsu_req_i    = 1'b0;
    lsu_w_en_i   = 1'b0;
    lsu_addr_i   = '0;
    lsu_w_data_i = '0;
    ack_en       = '1;
    stray        = '0;
    rd[0] = 32'h0000_0011;
    rd[1] = 32'h0000_00A5;
    rd[2] = 32'h0000_22C3;
    rd[3] = 32'h0000_0033;

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(lsu_ready_o), 32'd1);
    check("rst_rsp", 32'(lsu_rsp_o), 32'd0);
    check("rst_r_data", lsu_r_data_o, 32'd0);
    check("rst_err", 32'(lsu_err_o), 32'd0);
    check("rst_bus_nonzero", 32'(|dbus2peri_o), 32'd0);
    check("rst_sel", 32'(peri_sel_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write 0xFF to slot1 reg 0x04
    push(32'h0, 1'b0);
    accept(1'b1, 32'h9000_0104, 32'h0000_00FF, 1'b0);
    check("wr_sel", 32'(peri_sel_o), 32'h2);
    check("wr_addr", dbus2peri_o.addr, 32'h9000_0104);
    check("wr_w_en", 32'(dbus2peri_o.w_en), 32'd1);
    check("wr_w_data", dbus2peri_o.w_data, 32'h0000_00FF);
    count_req(n);
    check("wr_req_cycles", 32'(n), 32'd2);
    check("wr_sel_after", 32'(peri_sel_o), 32'd0);

    // Read slot1 reg 0x00
    push(32'h0000_00A5, 1'b0);
    accept(1'b0, 32'h9000_0100, 32'hDEAD_BEEF, 1'b0);
    check("rd_w_en", 32'(dbus2peri_o.w_en), 32'd0);
    check("rd_sel", 32'(peri_sel_o), 32'h2);
    count_req(n);
    check("rd_req_cycles", 32'(n), 32'd2);

    // Unmapped: slot index out of range, then wrong base
    push(32'h0, 1'b1);
    accept(1'b0, 32'h9000_0500, 32'h0, 1'b0);
    check("unmap_idx_req", 32'(dbus2peri_o.req), 32'd0);
    check("unmap_idx_rsp", 32'(lsu_rsp_o), 32'd1);
    @(negedge clk);
    push(32'h0, 1'b1);
    accept(1'b1, 32'h8000_0000, 32'h1234_5678, 1'b0);
    check("unmap_base_req", 32'(dbus2peri_o.req), 32'd0);
    check("unmap_base_rsp", 32'(lsu_rsp_o), 32'd1);
    @(negedge clk);

    // Highest mapped slot
    push(32'h0000_0033, 1'b0);
    accept(1'b0, 32'h9000_03FC, 32'h0, 1'b0);
    check("top_slot_sel", 32'(peri_sel_o), 32'h8);
    check("top_slot_offset", 32'(dbus2peri_o.addr[7:0]), 32'hFC);
    count_req(n);

    // Back-to-back with lsu_req_i held high
    b2b_addr[0] = 32'h9000_0000; b2b_data[0] = 32'h0000_0011;
    b2b_addr[1] = 32'h9000_0108; b2b_data[1] = 32'h0000_00A5;
    b2b_addr[2] = 32'h9000_0310; b2b_data[2] = 32'h0000_0033;
    for (int i = 0; i < 3; i++) push(b2b_data[i], 1'b0);
    for (int i = 0; i < 3; i++) begin
      accept(1'b0, b2b_addr[i], 32'h0, (i < 2));
      check("b2b_addr", dbus2peri_o.addr, b2b_addr[i]);
    end
    count_req(n);
    repeat (3) @(negedge clk);

    // Slot2 silent, stray ack on slot0 during WAIT
    ack_en[2] = 1'b0;
`ifdef DBUS_TIMEOUT_EN
    push(32'h0, 1'b1);
`else
    push(32'h0000_22C3, 1'b0);
`endif
    accept(1'b0, 32'h9000_0200, 32'h0, 1'b0);
    check("silent_sel", 32'(peri_sel_o), 32'h4);
    stray[0] = 1'b1;
    n = 0;
    while (dbus2peri_o.req === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
      if (n == 3) stray[0] = 1'b0;
    end
    stray[0] = 1'b0;
`ifdef DBUS_TIMEOUT_EN
    check("timeout_wait_cycles", 32'(n), 32'd16);
    check("timeout_req_low", 32'(dbus2peri_o.req), 32'd0);
    check("timeout_sel_low", 32'(peri_sel_o), 32'd0);
    ack_en[2] = 1'b1;
`else
    check("silent_still_waiting", 32'(dbus2peri_o.req), 32'd1);
    check("silent_ready_low", 32'(lsu_ready_o), 32'd0);
    ack_en[2] = 1'b1;
    count_req(n);
    check("late_ack_req_cycles", 32'(n), 32'd2);
`endif
    repeat (2) @(negedge clk);

    // Reset while in WAIT: transaction dropped, no response
    ack_en[2] = 1'b0;
    accept(1'b0, 32'h9000_0200, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_req", 32'(dbus2peri_o.req), 32'd0);
    check("midrst_sel", 32'(peri_sel_o), 32'd0);
    check("midrst_ready", 32'(lsu_ready_o), 32'd1);
    check("midrst_rsp", 32'(lsu_rsp_o), 32'd0);
    rst_n = 1'b1;
    ack_en[2] = 1'b1;
    @(negedge clk);
    push(32'h0000_22C3, 1'b0);
    accept(1'b0, 32'h9000_0204, 32'h0, 1'b0);
    count_req(n);
    check("post_rst_req_cycles", 32'(n), 32'd2);

    repeat (4) @(negedge clk);
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
